// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM state encoding and default operand width.
package alu_pkg;

    localparam int unsigned MULT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_BUSY = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/cla_32_bit.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained via group G/P.
module cla_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c0,
    output logic [31:0] sum,
    output logic        c_out
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [8:0]  cg;
    logic [7:0]  gg;
    logic [7:0]  pg;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c     = '0;
        cg    = '0;
        gg    = '0;
        pg    = '0;
        cg[0] = c0;
        for (int unsigned k = 0; k < 8; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
            gg[k]    = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k]    = &p[4*k +: 4];
            cg[k+1]  = gg[k] | (pg[k] & cg[k]);
        end
        c[32] = cg[8];
    end

    assign sum   = p ^ c[31:0];
    assign c_out = c[32];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-add multiplier control: FSM, iteration counter, load/step/done strobes.
// MULT_EARLY_TERM_EN adds the early_done input and exposes cnt for the datapath shifter.
module seq_mult_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         out_ready,
`ifdef MULT_EARLY_TERM_EN
    input  logic                         early_done,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
`endif
    output logic                         in_ready,
    output logic                         out_valid,
    output logic                         load,
    output logic                         step,
    output logic                         done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    mult_state_e state;
    logic        last;

`ifdef MULT_EARLY_TERM_EN
    assign last = (cnt == CW'(1)) || early_done;
`else
    logic [CW-1:0] cnt;
    assign last = (cnt == CW'(1));
`endif

    assign load = in_valid && in_ready;

    // done pulses on entry to DONE; out_valid follows one cycle later, once out_p is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MULT_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            step      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MULT_IDLE: begin
                    if (load) begin
                        state    <= MULT_BUSY;
                        cnt      <= CW'(WIDTH);
                        in_ready <= 1'b0;
                        step     <= 1'b1;
                    end
                end
                MULT_BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        state <= MULT_DONE;
                        cnt   <= '0;
                        step  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                MULT_DONE: begin
                    if (done) begin
                        out_valid <= 1'b1;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= MULT_IDLE;
                    end
                end
                default: begin
                    state <= MULT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_mult_32.sv
// Multi-cycle unsigned shift-add multiplier built on cla_32_bit (behavioural '+' when WIDTH != 32).
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_mult_32
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [2*WIDTH-1:0] prod_iter;
    logic [2*WIDTH-1:0] prod_next;
    logic               load;
    logic               step;
    logic               done;

    assign acc = prod[2*WIDTH-1:WIDTH];

    generate
        if (WIDTH == 32) begin : g_cla
            cla_32_bit u_cla (
                .a     (acc),
                .b     (mcand),
                .c0    (1'b0),
                .sum   (add_sum),
                .c_out (add_cout)
            );
        end else begin : g_behav
            assign {add_cout, add_sum} = {1'b0, acc} + {1'b0, mcand};
        end
    endgenerate

    always_comb begin
        prod_iter = '0;
        if (prod[0]) begin
            prod_iter = {add_cout, add_sum, prod[WIDTH-1:1]};
        end else begin
            prod_iter = {1'b0, acc, prod[WIDTH-1:1]};
        end
    end

`ifdef MULT_EARLY_TERM_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    shamt;
    logic [WIDTH-2:0] rem_mask;
    logic             early_done;

    // After this cycle's iteration, cnt-1 multiplier bits remain in prod[cnt-1:1];
    // if they are all zero the outstanding iterations reduce to a plain right shift.
    always_comb begin
        shamt      = cnt - 1'b1;
        rem_mask   = ~({(WIDTH-1){1'b1}} << shamt);
        early_done = ((prod[WIDTH-1:1] & rem_mask) == '0);
        prod_next  = early_done ? (prod_iter >> shamt) : prod_iter;
    end
`else
    assign prod_next = prod_iter;
`endif

    seq_mult_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
`ifdef MULT_EARLY_TERM_EN
        .early_done (early_done),
        .cnt        (cnt),
`endif
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .load       (load),
        .step       (step),
        .done       (done)
    );

    assign busy = step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            prod  <= '0;
            out_p <= '0;
        end else begin
            if (load) begin
                mcand <= in_a;
                prod  <= {{WIDTH{1'b0}}, in_b};
            end else if (step) begin
                prod <= prod_next;
            end
            if (done) begin
                out_p <= prod;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_32.sv
// Directed bench for seq_mult_32: latency, carry-out, back-pressure, busy-ignore, reset abort,
// random products; extra early-termination checks when MULT_EARLY_TERM_EN is defined.
module tb_seq_mult_32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_p;
    logic        busy;

    int unsigned n_checks;
    int unsigned n_fail;

    seq_mult_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("in_ready_before_start", 64'(in_ready), 64'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("in_ready_after_accept", 64'(in_ready), 64'd0);
        check("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_consume", 64'(out_valid), 64'd0);
        check("in_ready_after_consume", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int          lat;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_out_p", out_p, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 3*5, fixed latency
        start_op(32'd3, 32'd5);
        wait_valid(lat);
`ifndef MULT_EARLY_TERM_EN
        check("latency_3x5", 64'(lat), 64'd33);
`endif
        check("product_3x5", out_p, 64'd15);
        consume();

        // all-ones operands exercise the adder carry-out, then hold back-pressure
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(lat);
`ifndef MULT_EARLY_TERM_EN
        check("latency_ff", 64'(lat), 64'd33);
`endif
        check("product_ff", out_p, 64'hFFFF_FFFE_0000_0001);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_out_p", out_p, 64'hFFFF_FFFE_0000_0001);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        consume();
        check("idle_busy", 64'(busy), 64'd0);

        // operands offered mid-BUSY must be ignored
        start_op(32'h10, 32'h20);
        repeat (5) @(posedge clk);
        #1;
        in_a     = 32'd99;
        in_b     = 32'd99;
        in_valid = 1'b1;
        check("in_ready_mid_busy", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_after_ignored", 64'(busy), 64'd1);
        wait_valid(lat);
        check("product_ignore", out_p, 64'h200);
        consume();

        // asynchronous reset at iteration 10
        start_op(32'hDEAD, 32'hBEEF);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_p", out_p, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(32'd7, 32'd9);
        wait_valid(lat);
`ifndef MULT_EARLY_TERM_EN
        check("latency_7x9", 64'(lat), 64'd33);
`endif
        check("product_7x9", out_p, 64'd63);
        consume();

`ifdef MULT_EARLY_TERM_EN
        start_op(32'h1234, 32'd1);
        wait_valid(lat);
        check("early_latency_b1", 64'(lat), 64'd2);
        check("early_product_b1", out_p, 64'h1234);
        consume();
        start_op(32'hCAFE, 32'd0);
        wait_valid(lat);
        check("early_latency_b0", 64'(lat), 64'd2);
        check("early_product_b0", out_p, 64'd0);
        consume();
`endif

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = rb >> (i % 32);
            start_op(ra, rb);
            wait_valid(lat);
            check("random_product", out_p, 64'(ra) * 64'(rb));
            consume();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
